// File: rtl/d_inst_buffer_if.sv
// Fetch->decode packet type and the valid/ready handshake interface that carries it.
// The receiver modport is the consuming side of a link, the sender modport the producing side.
package d_inst_buffer_pkg;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } predict_info_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } fetch_exc_info_t;

  // One fetch packet: an aligned pair of instructions plus per-slot validity mask.
  typedef struct packed {
    logic [1:0]                mask;
    logic [31:0]               pc;
    logic [1:0][31:0]          insts;
    predict_info_t [1:0]       predict_infos;
    fetch_exc_info_t           fetch_exc_info;
  } f_d_pkg_t;

endpackage

interface handshake_if;
  import d_inst_buffer_pkg::*;

  logic     valid;
  logic     ready;
  f_d_pkg_t data;

  modport receiver (input valid, input data, output ready);
  modport sender   (output valid, output data, input ready);
endinterface

// File: rtl/d_inst_buffer.sv
// d_inst_buffer: in-order F->D packet queue, the only storage in the decode stage.
// Packets with an all-zero mask are acknowledged but dropped; flush discards everything.
// Optional feature macro: D_INST_BUFFER_BYPASS_EN (empty-queue zero-latency pass-through).
module d_inst_buffer
  import d_inst_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  handshake_if.receiver              receiver,
  handshake_if.sender                sender,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  f_d_pkg_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  logic full;
  logic empty;
  logic pkt_live;
  logic enq;
  logic deq;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  // A live packet carries at least one real instruction and is not being flushed away.
  assign pkt_live = receiver.valid & (|receiver.data.mask) & ~flush;

  // Ready depends only on stored state, so back-pressure never ripples combinationally.
  assign receiver.ready = ~full;

`ifdef D_INST_BUFFER_BYPASS_EN
  logic bypass_active;
  logic bypass_taken;

  // With nothing queued, the incoming packet is presented directly to the decoder.
  assign bypass_active = empty & pkt_live;
  assign bypass_taken  = bypass_active & sender.ready;

  assign sender.valid = ~empty | bypass_active;
  assign sender.data  = empty ? receiver.data : mem[rd_ptr_reg];

  // A packet consumed on the bypass path must not also be written into the queue.
  assign enq = pkt_live & receiver.ready & ~bypass_taken;
`else
  assign sender.valid = ~empty;
  assign sender.data  = mem[rd_ptr_reg];

  assign enq = pkt_live & receiver.ready;
`endif

  // A handshake during flush is not a dequeue; the entry is discarded with the rest.
  assign deq = ~empty & sender.ready & ~flush;

  assign occupancy = count_reg;

  // Next-state for pointers and occupancy; flush collapses the queue to empty.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (enq) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Packet storage write port; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr_reg] <= receiver.data;
    end
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_reg <= CNT_W'(DEPTH));
  a_no_enq_full: assert property (@(posedge clk) disable iff (rst) !(enq && full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(deq && empty));
`endif

endmodule

// File: tb/tb_d_inst_buffer.sv
// Randomised bench for d_inst_buffer: a queue-based reference model checked every cycle,
// plus literal expectations in the directed phases.
module tb_d_inst_buffer;
  import d_inst_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [CNT_W-1:0] occupancy;

  handshake_if rx_if ();
  handshake_if tx_if ();

  d_inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .receiver  (rx_if),
    .sender    (tx_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  f_d_pkg_t model_q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic f_d_pkg_t rand_pkt(input bit allow_zero);
    f_d_pkg_t p;
    p.mask  = 2'($urandom_range(allow_zero ? 0 : 1, 3));
    p.pc    = {$urandom} & 32'hffff_fff8;
    p.insts[0] = $urandom;
    p.insts[1] = $urandom;
    p.predict_infos[0].taken  = 1'($urandom);
    p.predict_infos[0].target = $urandom;
    p.predict_infos[1].taken  = 1'($urandom);
    p.predict_infos[1].target = $urandom;
    p.fetch_exc_info.valid = 1'($urandom);
    p.fetch_exc_info.code  = 4'($urandom);
    return p;
  endfunction

  // Reference model: compare what the outputs must be, then apply this cycle's transfers.
  always @(negedge clk) begin
    int  sz;
    bit  consumed;
    bit  do_deq;
    bit  do_enq;
    bit  live;
    sz   = model_q.size();
    live = rx_if.valid && (rx_if.data.mask != 2'b00) && !flush;
    if (check_en && !rst) begin
`ifdef D_INST_BUFFER_BYPASS_EN
      chk("valid", tx_if.valid, (sz > 0) || live);
      if (sz > 0) chk("data", tx_if.data, model_q[0]);
      else if (live) chk("bypass_data", tx_if.data, rx_if.data);
`else
      chk("valid", tx_if.valid, sz > 0);
      if (sz > 0) chk("data", tx_if.data, model_q[0]);
`endif
      chk("ready", rx_if.ready, sz < DEPTH);
      chk("occupancy", occupancy, sz);
    end
    if (rst || flush) begin
      model_q.delete();
    end else begin
      consumed = 1'b0;
`ifdef D_INST_BUFFER_BYPASS_EN
      consumed = (sz == 0) && live && tx_if.ready;
`endif
      do_deq = (sz > 0) && tx_if.ready;
      do_enq = live && (sz < DEPTH) && !consumed;
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(rx_if.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    f_d_pkg_t pa, pb;
    rst         = 1'b1;
    flush       = 1'b0;
    rx_if.valid = 1'b0;
    rx_if.data  = '0;
    tx_if.ready = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_valid", tx_if.valid, 1'b0);
    chk("rst_ready", rx_if.ready, 1'b1);
    chk("rst_occ", occupancy, 0);

    // Fill to full with back-pressure, then drain in order
    for (int k = 0; k < DEPTH; k++) begin
      rx_if.valid = 1'b1;
      rx_if.data  = rand_pkt(1'b0);
      rx_if.data.mask = 2'b11;
      rx_if.data.pc   = 32'h1c00_0000 + 32'(8 * k);
      tick();
    end
    rx_if.valid = 1'b0;
    chk("fill_occ", occupancy, 8);
    chk("fill_ready", rx_if.ready, 1'b0);
    tx_if.ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("fill_pc", tx_if.data.pc, 32'h1c00_0000 + 32'(8 * k));
      tick();
    end
    chk("drained_valid", tx_if.valid, 1'b0);

    // Streaming: one packet per cycle
    for (int k = 0; k < 100; k++) begin
      rx_if.valid = 1'b1;
      rx_if.data  = rand_pkt(1'b0);
      tick();
`ifdef D_INST_BUFFER_BYPASS_EN
      chk("stream_occ", occupancy, 0);
`else
      chk("stream_occ", occupancy, 1);
`endif
    end
    rx_if.valid = 1'b0;
    tick();

    // Zero-mask packet between two real ones
    tx_if.ready = 1'b0;
    pa = rand_pkt(1'b0);
    pb = rand_pkt(1'b0);
    rx_if.valid = 1'b1;
    rx_if.data = pa; tick();
    rx_if.data = rand_pkt(1'b0); rx_if.data.mask = 2'b00; tick();
    rx_if.data = pb; tick();
    rx_if.valid = 1'b0;
    chk("zmask_occ", occupancy, 2);
    tx_if.ready = 1'b1;
    chk("zmask_first", tx_if.data.pc, pa.pc);
    tick();
    chk("zmask_second", tx_if.data.pc, pb.pc);
    tick();
    chk("zmask_empty", tx_if.valid, 1'b0);

    // Flush with an incoming packet
    tx_if.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rx_if.valid = 1'b1;
      rx_if.data  = rand_pkt(1'b0);
      tick();
    end
    chk("flush_pre_occ", occupancy, 5);
    flush = 1'b1;
    rx_if.data = rand_pkt(1'b0);
    tx_if.ready = 1'b1;
    tick();
    flush = 1'b0;
    rx_if.valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", tx_if.valid, 1'b0);

    // Wrap: alternate push and pop
    for (int k = 0; k < 3 * DEPTH; k++) begin
      rx_if.valid = 1'b1; tx_if.ready = 1'b0;
      rx_if.data = rand_pkt(1'b0);
      tick();
      rx_if.valid = 1'b0; tx_if.ready = 1'b1;
      tick();
    end
    chk("wrap_occ", occupancy, 0);
    tx_if.ready = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      rx_if.valid = 1'b1;
      rx_if.data = rand_pkt(1'b0);
      tick();
    end
    chk("wrap_fill_occ", occupancy, DEPTH - 1);
    tx_if.ready = 1'b1;
    rx_if.data = rand_pkt(1'b0);
    tick();
    chk("wrap_simul_occ", occupancy, DEPTH - 1);
    tx_if.ready = 1'b0;
    rx_if.data = rand_pkt(1'b0);
    tick();
    chk("wrap_full_occ", occupancy, DEPTH);
    chk("wrap_full_ready", rx_if.ready, 1'b0);
    tx_if.ready = 1'b1;
    rx_if.data = rand_pkt(1'b0);
    tick();
    chk("wrap_blocked_occ", occupancy, DEPTH - 1);
    rx_if.valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) tick();
    chk("wrap_drained", occupancy, 0);

    // Random traffic including flush and occasional reset
    for (int k = 0; k < 600; k++) begin
      rx_if.valid = ($urandom_range(0, 3) != 0);
      rx_if.data  = rand_pkt(1'b1);
      tx_if.ready = ($urandom_range(0, 2) != 0) && (k % 64 < 40);
      flush       = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; rx_if.valid = 1'b0; tx_if.ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) tick();
    chk("final_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
